// File: rtl/key_event_ctrl.sv
// Debounces three active-low keys and offers press/release events downstream
// over a valid/ready handshake, one key at a time, chosen round-robin.
//
// state | meaning
// IDLE  | no event offered; look for a key whose debounced level was not yet reported
// OFFER | event latched on evt_key/evt_press, waiting for evt_ready
module key_event_ctrl #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] key_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_key,
    output logic       evt_press,
    output logic [2:0] key_state,
    output logic [7:0] evt_count
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       sync_a, sync_b;
    logic [2:0]       stable, rep, pending;
    logic [CNT_W-1:0] db_cnt [3];
    logic [1:0]       last_grant, grant_key;
    logic [1:0]       evt_key_q;
    logic             evt_press_q;
    logic [7:0]       count_q;

    function automatic logic [1:0] inc3(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_a <= 3'b111;
            sync_b <= 3'b111;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // counter tracks how long the synchronized level has disagreed with stable
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stable <= 3'b000;
            for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (~sync_b[k] == stable[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db_cnt[k] <= '0;
                    stable[k] <= ~stable[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign pending = stable ^ rep;

    // nearest pending key after last_grant wins; loop runs far-to-near so near overrides
    always_comb begin
        logic [1:0] cand [3];
        cand[0]   = inc3(last_grant);
        cand[1]   = inc3(cand[0]);
        cand[2]   = inc3(cand[1]);
        grant_key = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (pending[cand[i]]) grant_key = cand[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending)  state_nxt = OFFER;
            OFFER:   if (evt_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        evt_valid = (state == OFFER);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            evt_key_q   <= 2'd0;
            evt_press_q <= 1'b0;
            rep         <= 3'b000;
            last_grant  <= 2'd2;
            count_q     <= 8'd0;
        end else begin
            if (state == IDLE && |pending) begin
                evt_key_q   <= grant_key;
                evt_press_q <= stable[grant_key];
            end
            if (state == OFFER && evt_ready) begin
                rep[evt_key_q] <= evt_press_q;
                last_grant     <= evt_key_q;
                count_q        <= count_q + 8'd1;
            end
        end
    end

    assign evt_key   = evt_key_q;
    assign evt_press = evt_press_q;
    assign key_state = stable;
    assign evt_count = count_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed vector table, hand sequences for the
// handshake/reset corners, then random keys checked against a window model.
module tb_key_event_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_key;
    logic       evt_press;
    logic [2:0] key_state;
    logic [7:0] evt_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    key_event_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_n     (key_n),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_press (evt_press),
        .key_state (key_state),
        .evt_count (evt_count)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a key's debounced level flips once the last DB
    // synchronized samples all disagree with it; events come from a one-slot
    // offer that is refilled round-robin from keys whose level was not reported.
    bit [2:0] m_s1, m_s2, m_stable, m_rep, m_pend;
    bit       m_hist [3][DB];
    bit       m_busy, m_press, m_all;
    int       m_key, m_cnt, m_lg;

    always @(posedge clk) begin
        if (!resetn) begin
            m_s1 = 3'b111; m_s2 = 3'b111;
            m_stable = 3'b000; m_rep = 3'b000;
            for (int k = 0; k < 3; k++) for (int j = 0; j < DB; j++) m_hist[k][j] = 1'b0;
            m_busy = 1'b0; m_key = 0; m_press = 1'b0; m_cnt = 0; m_lg = 2;
        end else begin
            if (m_busy) begin
                if (evt_ready) begin
                    m_rep[m_key] = m_press;
                    m_lg = m_key;
                    m_cnt = (m_cnt + 1) % 256;
                    m_busy = 1'b0;
                end
            end else begin
                m_pend = m_stable ^ m_rep;
                for (int i = 1; i <= 3; i++) begin
                    if (!m_busy && m_pend[(m_lg + i) % 3]) begin
                        m_busy = 1'b1;
                        m_key = (m_lg + i) % 3;
                        m_press = m_stable[m_key];
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                for (int j = DB - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = ~m_s2[k];
                m_all = 1'b1;
                for (int j = 0; j < DB; j++) if (m_hist[k][j] == m_stable[k]) m_all = 1'b0;
                if (m_all) m_stable[k] = ~m_stable[k];
            end
            m_s2 = m_s1;
            m_s1 = key_n;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_valid", int'(evt_valid), int'(m_busy));
            cmp("model_key_state", int'(key_state), int'(m_stable));
            cmp("model_count", int'(evt_count), m_cnt);
            if (m_busy) begin
                cmp("model_key", int'(evt_key), m_key);
                cmp("model_press", int'(evt_press), int'(m_press));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] ks, input bit v,
                       input logic [1:0] k, input bit p, input int cnt);
        cmp({nm, "_key_state"}, int'(key_state), int'(ks));
        cmp({nm, "_valid"}, int'(evt_valid), int'(v));
        cmp({nm, "_count"}, int'(evt_count), cnt);
        if (v) begin
            cmp({nm, "_key"}, int'(evt_key), int'(k));
            cmp({nm, "_press"}, int'(evt_press), int'(p));
        end
    endtask

    typedef struct {
        bit         rst;
        logic [2:0] kn;
        bit         rdy;
        int         cyc;
        logic [2:0] ks;
        bit         v;
        logic [1:0] k;
        bit         p;
        int         cnt;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int bit_idx;

        tbl[0]  = '{0, 3'b111, 0, 50, 3'b000, 0, 2'd0, 0, 0};
        tbl[1]  = '{0, 3'b110, 1,  5, 3'b000, 0, 2'd0, 0, 0};
        tbl[2]  = '{0, 3'b110, 1,  1, 3'b001, 0, 2'd0, 0, 0};
        tbl[3]  = '{0, 3'b110, 1,  1, 3'b001, 1, 2'd0, 1, 0};
        tbl[4]  = '{0, 3'b110, 1,  1, 3'b001, 0, 2'd0, 0, 1};
        tbl[5]  = '{0, 3'b110, 1, 10, 3'b001, 0, 2'd0, 0, 1};
        tbl[6]  = '{0, 3'b100, 1,  3, 3'b001, 0, 2'd0, 0, 1};
        tbl[7]  = '{0, 3'b110, 1, 20, 3'b001, 0, 2'd0, 0, 1};
        tbl[8]  = '{0, 3'b111, 1,  8, 3'b000, 0, 2'd0, 0, 2};
        tbl[9]  = '{1, 3'b111, 0,  2, 3'b000, 0, 2'd0, 0, 0};
        tbl[10] = '{0, 3'b010, 1,  6, 3'b101, 0, 2'd0, 0, 0};
        tbl[11] = '{0, 3'b010, 1,  1, 3'b101, 1, 2'd0, 1, 0};
        tbl[12] = '{0, 3'b010, 1,  1, 3'b101, 0, 2'd0, 0, 1};
        tbl[13] = '{0, 3'b010, 1,  1, 3'b101, 1, 2'd2, 1, 1};
        tbl[14] = '{0, 3'b010, 1,  1, 3'b101, 0, 2'd0, 0, 2};

        resetn = 1'b0; key_n = 3'b111; evt_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset", 3'b000, 0, 2'd0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            resetn    = !tbl[i].rst;
            key_n     = tbl[i].kn;
            evt_ready = tbl[i].rdy;
            repeat (tbl[i].cyc) tick();
            chk($sformatf("vec%0d", i), tbl[i].ks, tbl[i].v, tbl[i].k, tbl[i].p, tbl[i].cnt);
        end
        resetn = 1'b1;

        // Press and release key 1 while its press is stalled on evt_ready=0
        evt_ready = 1'b0; key_n = 3'b000;
        repeat (7) tick();
        chk("hold_offer", 3'b111, 1, 2'd1, 1, 2);
        key_n = 3'b010;
        repeat (10) tick();
        chk("hold_stable", 3'b101, 1, 2'd1, 1, 2);
        evt_ready = 1'b1;
        tick(); chk("hold_xfer", 3'b101, 0, 2'd0, 0, 3);
        tick(); chk("release_offer", 3'b101, 1, 2'd1, 0, 3);
        tick(); chk("release_xfer", 3'b101, 0, 2'd0, 0, 4);

        // Key 1 bounces fully while key 0's release is being offered
        evt_ready = 1'b0; key_n = 3'b011;
        repeat (7) tick();
        chk("k0_offer", 3'b100, 1, 2'd0, 0, 4);
        key_n = 3'b001;
        repeat (7) tick();
        chk("k1_press_blocked", 3'b110, 1, 2'd0, 0, 4);
        key_n = 3'b011;
        repeat (7) tick();
        chk("k1_release_blocked", 3'b100, 1, 2'd0, 0, 4);
        evt_ready = 1'b1;
        tick(); chk("k0_xfer", 3'b100, 0, 2'd0, 0, 5);
        repeat (10) tick();
        chk("k1_cancelled", 3'b100, 0, 2'd0, 0, 5);

        // Reset while offering a held key 0
        key_n = 3'b111;
        repeat (10) tick();
        chk("k2_release_done", 3'b000, 0, 2'd0, 0, 6);
        evt_ready = 1'b0; key_n = 3'b110;
        repeat (7) tick();
        chk("pre_rst_offer", 3'b001, 1, 2'd0, 1, 6);
        resetn = 1'b0;
        tick(); chk("rst_drop", 3'b000, 0, 2'd0, 0, 0);
        resetn = 1'b1;
        repeat (6) tick();
        chk("redebounce", 3'b001, 0, 2'd0, 0, 0);
        tick(); chk("repress_offer", 3'b001, 1, 2'd0, 1, 0);
        evt_ready = 1'b1;
        tick(); chk("repress_xfer", 3'b001, 0, 2'd0, 0, 1);

        // Random key activity, handshake stalls and occasional reset
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(7) == 0) begin
                bit_idx = $urandom_range(2);
                key_n[bit_idx] = ~key_n[bit_idx];
            end
            evt_ready = 1'($urandom_range(1));
            resetn    = ($urandom_range(999) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
